// File: rtl/fir_filter_ctrl_pkg.sv
// Shared definitions for the filter blocks: controller state encoding and counter width.
package fir_filter_ctrl_pkg;

    localparam int CNT_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/fir_filter_ctrl_if.sv
// Control/handshake bundle between the FIR controller and its environment.
// Handshake: a window moves when in_valid && in_ready; a pixel moves when out_valid && out_ready.
interface fir_filter_ctrl_if;
    import fir_filter_ctrl_pkg::*;

    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic             out_ready;
    logic             out_valid;
    logic             output_en;
    logic             mac_en;
    logic             mac_clr;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic             busy;
    logic             done;
    ctrl_state_t      state_dbg;

    modport master (
        output start, in_valid, out_ready,
        input  in_ready, out_valid, output_en, mac_en, mac_clr,
        input  col, row, busy, done, state_dbg
    );

    modport slave (
        input  start, in_valid, out_ready,
        output in_ready, out_valid, output_en, mac_en, mac_clr,
        output col, row, busy, done, state_dbg
    );

endinterface

// File: rtl/fir_win_counter.sv
// Column/row position of the next window; wraps columns at IMG_W-1 and holds at the last window.
module fir_win_counter
    import fir_filter_ctrl_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             last
);

    localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(IMG_H - 1);

    assign last = (col == COL_MAX) && (row == ROW_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en && !last) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fir_filter_ctrl.sv
// FIR window controller: sequences one image through a two-stage (sum, saturate) datapath
// with output backpressure, counting window positions and pulsing done at the end.
module fir_filter_ctrl
    import fir_filter_ctrl_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    fir_filter_ctrl_if.slave  ctl
);

    ctrl_state_t state, state_n;
    logic        v1, v2, v1_n, v2_n;
    logic        adv, mac_en, acc_en, cnt_clr, last;

    fir_win_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_win_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (acc_en),
        .col   (ctl.col),
        .row   (ctl.row),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            v1    <= 1'b0;
            v2    <= 1'b0;
        end else begin
            state <= state_n;
            v1    <= v1_n;
            v2    <= v2_n;
        end
    end

    always_comb begin
        state_n = state;
        v1_n    = v1;
        v2_n    = v2;
        // Both pipeline stages move together, and only when the output stage can drain.
        adv     = !v2 || ctl.out_ready;
        mac_en  = adv && (((state == ST_RUN) && ctl.in_valid) ||
                          ((state == ST_DRAIN) && (v1 || v2)));
        acc_en  = (state == ST_RUN) && mac_en;
        // Counters restart on the accepted start so CLR already shows position (0,0).
        cnt_clr = (state == ST_IDLE) && ctl.start;

        if (state == ST_CLR) begin
            v1_n = 1'b0;
            v2_n = 1'b0;
        end else if (mac_en) begin
            v1_n = (state == ST_RUN) && ctl.in_valid;
            v2_n = v1;
        end else if (v2 && ctl.out_ready) begin
            v2_n = 1'b0;
        end

        case (state)
            ST_IDLE:  if (ctl.start) state_n = ST_CLR;
            ST_CLR:   state_n = ST_RUN;
            ST_RUN:   if (acc_en && last) state_n = ST_DRAIN;
            ST_DRAIN: if (!v1_n && !v2_n) state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        ctl.mac_en    = mac_en;
        ctl.in_ready  = acc_en;
        ctl.mac_clr   = (state == ST_CLR);
        ctl.out_valid = v2;
        ctl.output_en = v2 && ctl.out_ready;
        ctl.busy      = (state != ST_IDLE);
        ctl.done      = (state == ST_DONE);
        ctl.state_dbg = state;
    end

endmodule

// File: tb/tb_fir_filter_ctrl.sv
// Bench for fir_filter_ctrl on a 4x2 image: directed windows, scoreboarded pixel order and counts.
module tb_fir_filter_ctrl;
    import fir_filter_ctrl_pkg::*;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_filter_ctrl_if ctl ();

    fir_filter_ctrl #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (ctl)
    );

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0] exp_q[$];
    int cur_win = 0;
    int s1 = 0;
    int s2 = 0;
    int n_clr, n_acc, n_out, n_done, n_mac, n_drain;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic clear_counts();
        n_clr = 0; n_acc = 0; n_out = 0; n_done = 0; n_mac = 0; n_drain = 0;
    endtask

    // Monitor: samples mid-cycle, i.e. the values the DUT presents at the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ctl.mac_clr) begin
                n_clr++;
                check("clr_col", int'(ctl.col), 0);
                check("clr_row", int'(ctl.row), 0);
                check("clr_mac_en", int'(ctl.mac_en), 0);
            end
            if (ctl.state_dbg != ST_RUN) check("in_ready_outside_run", int'(ctl.in_ready), 0);
            if (ctl.out_valid && !ctl.out_ready) check("hold_mac_en", int'(ctl.mac_en), 0);
            check("output_en_rule", int'(ctl.output_en), int'(ctl.out_valid && ctl.out_ready));
            if (ctl.in_ready) begin
                n_acc++;
                check("acc_col", int'(ctl.col), cur_win % W);
                check("acc_row", int'(ctl.row), cur_win / W);
            end
            if (ctl.output_en) begin
                if (n_out == 0) check("first_out_latency", n_mac, 2);
                n_out++;
                check("sb_nonempty", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("pixel_order", s2, int'(exp_q.pop_front()));
            end
            if (ctl.mac_en) begin
                n_mac++;
                if (ctl.state_dbg == ST_DRAIN) n_drain++;
                s2 = s1;
                s1 = cur_win;
            end
            if (ctl.done) n_done++;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 ctl.start = 1'b1;
        @(posedge clk); #1 ctl.start = 1'b0;
    endtask

    task automatic send_window(input int id);
        int k;
        @(posedge clk); #1;
        ctl.in_valid = 1'b1;
        cur_win = id;
        exp_q.push_back(8'(id));
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ctl.in_ready) break;
        end
        check("accept_timeout", int'(k < 60), 1);
    endtask

    task automatic send_range(input int first, input int last_id);
        for (int i = first; i <= last_id; i++) send_window(i);
        @(posedge clk); #1 ctl.in_valid = 1'b0;
    endtask

    task automatic finish_image(input string tag, input bit check_drain);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (n_done > 0) break;
        end
        check({tag, "_done_seen"}, int'(k < 200), 1);
        @(negedge clk); #1;
        check({tag, "_done_pulses"}, n_done, 1);
        check({tag, "_clr_pulses"}, n_clr, 1);
        check({tag, "_accepts"}, n_acc, N);
        check({tag, "_outputs"}, n_out, N);
        check({tag, "_sb_left"}, exp_q.size(), 0);
        check({tag, "_idle"}, int'(ctl.state_dbg), int'(ST_IDLE));
        check({tag, "_busy"}, int'(ctl.busy), 0);
        if (check_drain) check({tag, "_drain_mac"}, n_drain, 2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mac_en"}, int'(ctl.mac_en), 0);
        check({tag, "_mac_clr"}, int'(ctl.mac_clr), 0);
        check({tag, "_in_ready"}, int'(ctl.in_ready), 0);
        check({tag, "_output_en"}, int'(ctl.output_en), 0);
        check({tag, "_out_valid"}, int'(ctl.out_valid), 0);
        check({tag, "_busy"}, int'(ctl.busy), 0);
        check({tag, "_done"}, int'(ctl.done), 0);
        check({tag, "_col"}, int'(ctl.col), 0);
        check({tag, "_row"}, int'(ctl.row), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl.start = 1'b0;
        ctl.in_valid = 1'b0;
        ctl.out_ready = 1'b1;
        clear_counts();

        // Reset state
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        check("reset_state", int'(ctl.state_dbg), int'(ST_IDLE));
        @(posedge clk); #1 rst_n = 1'b1;

        // Image 1: continuous flow
        clear_counts();
        pulse_start();
        send_range(0, N - 1);
        finish_image("img_basic", 1'b1);

        // Image 2: 1,0,0,1 input gap mid-row with a stray start during RUN
        clear_counts();
        pulse_start();
        send_window(0);
        send_window(1);
        @(posedge clk); #1 ctl.in_valid = 1'b0; ctl.start = 1'b1;
        @(posedge clk); #1 ctl.start = 1'b0;
        check("gap_col_held", int'(ctl.col), 2);
        check("gap_row_held", int'(ctl.row), 0);
        send_range(2, N - 1);
        finish_image("img_gap", 1'b1);

        // Image 3: five cycles of backpressure once a pixel is presented
        clear_counts();
        pulse_start();
        fork
            send_range(0, N - 1);
            begin
                int k;
                for (k = 0; k < 60; k++) begin
                    @(negedge clk);
                    if (ctl.out_valid) break;
                end
                check("bp_out_valid_seen", int'(k < 60), 1);
                @(posedge clk); #1 ctl.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_mac_en", int'(ctl.mac_en), 0);
                    check("bp_in_ready", int'(ctl.in_ready), 0);
                    check("bp_out_valid", int'(ctl.out_valid), 1);
                end
                @(posedge clk); #1 ctl.out_ready = 1'b1;
            end
        join
        finish_image("img_bp", 1'b0);

        // Image 4: reset asserted in DRAIN, then a fresh image
        clear_counts();
        pulse_start();
        for (int i = 0; i < N; i++) send_window(i);
        @(posedge clk); #1 ctl.in_valid = 1'b0;
        check("pre_reset_drain", int'(ctl.state_dbg), int'(ST_DRAIN));
        check("pre_reset_out_valid", int'(ctl.out_valid), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("drain_reset");
        exp_q.delete();
        s1 = 0;
        s2 = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_counts();
        pulse_start();
        send_range(0, N - 1);
        finish_image("img_after_reset", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fir_filter_ctrl.md
FIR_FILTER_CTRL -- requirements
Module: fir_filter_ctrl

Interface
REQ-001 Parameter IMG_W, default 640: windows per image row (range 2..1023).
REQ-002 Parameter IMG_H, default 480: window rows per image (range 2..1023).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin one image; ignored unless in IDLE.
REQ-006 in_valid  in  1  3x3 RGB window presented to the acc/output datapath is valid.
REQ-007 in_ready  out  1  window is consumed this cycle (equals mac_en while in RUN).
REQ-008 out_ready  in  1  downstream can accept the saturated output pixel.
REQ-009 mac_en  out  1  datapath advance strobe; shifts both the sum and saturation stages.
REQ-010 mac_clr  out  1  one-cycle clear pulse to the datapath at image start.
REQ-011 output_en  out  1  downstream write strobe; equals out_valid && out_ready.
REQ-012 out_valid  out  1  output_data_pipe holds a valid pixel.
REQ-013 col  out  10  column index of the next window to be accepted.
REQ-014 row  out  10  row index of the next window to be accepted.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse when the last pixel of the image is accepted downstream.

Function
REQ-017 FSM states SHALL be IDLE, CLR, RUN, DRAIN, DONE.
REQ-018 IDLE -> CLR on start; CLR lasts exactly one cycle with mac_clr=1, col=0, row=0, then -> RUN.
REQ-019 Valid tracking: two flags v1 (sum stage) and v2 (saturation stage); out_valid = v2.
REQ-020 adv = (!v2 || out_ready); mac_en = adv && ((RUN && in_valid) || (DRAIN && (v1 || v2))).
REQ-021 On mac_en: v1 <= (RUN && in_valid), v2 <= v1; output latency is exactly 2 mac_en pulses.
REQ-022 When v2 && out_ready && !mac_en, v2 SHALL clear; output data is never overwritten while out_valid && !out_ready.
REQ-023 On each accepted window (RUN && mac_en): col increments; at col=IMG_W-1 col wraps to 0 and row increments.
REQ-024 Acceptance of window (IMG_W-1, IMG_H-1) SHALL move RUN -> DRAIN; row/col then hold at their final values.
REQ-025 DRAIN issues mac_en pulses (subject to adv) until v1=v2=0 with the last pixel accepted; then -> DONE.
REQ-026 DONE lasts one cycle with done=1, then -> IDLE.
REQ-027 in_ready SHALL be 0 in all states except RUN; mac_en SHALL be 0 in IDLE, CLR, DONE.
REQ-028 start asserted while busy SHALL be ignored and SHALL not restart or corrupt counters.
REQ-029 in_valid deasserting mid-row SHALL stall counters and v1 without losing the held output.
REQ-030 Total output_en pulses per image SHALL equal IMG_W*IMG_H.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, v1=v2=0, col=row=0, and all outputs 0 (mac_en, mac_clr, in_ready, output_en, out_valid, busy, done).
REQ-032 Reset asserted mid-image SHALL abandon the image; the next start begins a fresh image with mac_clr.

Structure
REQ-033 The FSM state encoding and the 10-bit counter width constant SHALL live in a shared filter package used by all filter blocks.
REQ-034 The row/column counter SHALL be one sub-module, fir_win_counter (enable, wrap at IMG_W-1, last flag); the rest is flat.

Verification
REQ-035 Reset then start, IMG_W=4, IMG_H=2, in_valid=1, out_ready=1 -> mac_clr one cycle; 8 in_ready pulses; 8 output_en pulses, the first 2 mac_en after the first acceptance; done one cycle; then IDLE.
REQ-036 Backpressure: out_ready=0 for 5 cycles once out_valid=1 -> mac_en=0 and in_ready=0 throughout; out_valid held; the pixel is delivered exactly once when out_ready rises.
REQ-037 Input gaps: in_valid toggling 1,0,0,1 mid-row -> col advances only on cycles with in_valid=1; output count is unchanged at 8.
REQ-038 Row wrap: 4th acceptance in row 0 -> col=0, row=1 on the next cycle; last acceptance -> DRAIN with exactly 2 drain mac_en pulses when out_ready=1.
REQ-039 start pulsed during RUN -> no mac_clr pulse; col/row unaffected.
REQ-040 rst_n asserted during DRAIN -> all outputs 0 asynchronously; a subsequent start yields a full 8-pixel image.
